// File: rtl/spi_flash_rd_seq.sv
// Purpose : drives the SPI master register port to run NOR flash READ transactions and streams payload bytes out.
// Latency : per byte CS/LOAD/KICK writes, then polls status busy high->low (bounded by TIMEOUT), then fetches data.
// Backpr. : a payload byte is held on rd_data_o/rd_valid_o until rd_ready_i; no SPI access happens while stalled.
//
// Ports:
//   clk, rstn                   system clock, asynchronous active-low reset
//   req_i/req_addr_i/req_len_i  read request (24-bit flash address, byte count, 0 = 256), taken only when idle
//   busy_o, done_o, err_o       busy for the whole transaction, one-cycle done pulse, timeout flag held until next request
//   rd_data_o/rd_valid_o/rd_ready_i  payload byte stream
//   spi_addr_o/spi_wdata_o/spi_we_o/spi_rdata_i  SPI register port (ctrl +0x0, data +0x4, status +0x8)
//
// Build option: define SPI_FLASH_FAST_READ_EN for FAST READ (0x0B plus one discarded dummy byte after the
// address); otherwise plain READ (0x03) with a 4-byte header.

module spi_flash_rd_seq #(
    parameter logic [31:0] SPI_BASE = 32'h0,
    parameter logic [7:0]  CLK_DIV  = 8'd0,
    parameter logic        CPOL     = 1'b0,
    parameter logic        CPHA     = 1'b0,
    parameter logic [15:0] TIMEOUT  = 16'd1023
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_i,
    input  logic [23:0] req_addr_i,
    input  logic [7:0]  req_len_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [7:0]  rd_data_o,
    output logic        rd_valid_o,
    input  logic        rd_ready_i,
    output logic [31:0] spi_addr_o,
    output logic [31:0] spi_wdata_o,
    output logic        spi_we_o,
    input  logic [31:0] spi_rdata_i
);

`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [7:0] CMD_BYTE = 8'h0B;
    localparam logic [2:0] HDR_LEN  = 3'd5;
`else
    localparam logic [7:0] CMD_BYTE = 8'h03;
    localparam logic [2:0] HDR_LEN  = 3'd4;
`endif

    localparam logic [31:0] ADDR_CTRL   = SPI_BASE;
    localparam logic [31:0] ADDR_DATA   = SPI_BASE + 32'd4;
    localparam logic [31:0] ADDR_STATUS = SPI_BASE + 32'd8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CS_ON,
        S_LOAD,
        S_KICK,
        S_WAIT_HI,
        S_WAIT_LO,
        S_FETCH,
        S_OUT,
        S_NEXT,
        S_CS_OFF,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] addr_q, addr_d;
    logic [8:0]  rem_q, rem_d;          // payload bytes still to transfer, including the current one
    logic [2:0]  hdr_idx_q, hdr_idx_d;  // header byte index; equals HDR_LEN once the payload phase starts
    logic [15:0] tmo_q, tmo_d;
    logic        err_q, err_d;
    logic [7:0]  rd_data_q, rd_data_d;

    logic [7:0]  cur_byte;
    logic        is_hdr;
    logic        spi_busy;
    logic        tmo_hit;

    // Only the low byte of data and bit 0 of status carry information for this sequencer.
    logic        unused_rdata;
    assign unused_rdata = ^spi_rdata_i[31:8];

    function automatic logic [31:0] ctrl_word(input logic ss, input logic en);
        return {16'h0, CLK_DIV, 4'h0, ss, CPHA, CPOL, en};
    endfunction

    // Byte shifted out for the current slot: header bytes first, then 0x00 dummies that clock the payload in.
    always_comb begin
        cur_byte = 8'h00;
        case (hdr_idx_q)
            3'd0:    cur_byte = CMD_BYTE;
            3'd1:    cur_byte = addr_q[23:16];
            3'd2:    cur_byte = addr_q[15:8];
            3'd3:    cur_byte = addr_q[7:0];
            default: cur_byte = 8'h00;
        endcase
    end

    assign is_hdr   = (hdr_idx_q < HDR_LEN);
    assign spi_busy = spi_rdata_i[0];
    // True on the TIMEOUT-th consecutive cycle spent in a poll state.
    assign tmo_hit  = ({1'b0, tmo_q} + 17'd1) >= {1'b0, TIMEOUT};

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        hdr_idx_d   = hdr_idx_q;
        tmo_d       = tmo_q;
        err_d       = err_q;
        rd_data_d   = rd_data_q;
        spi_addr_o  = ADDR_STATUS;
        spi_wdata_o = 32'h0;
        spi_we_o    = 1'b0;
        done_o      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    addr_d    = req_addr_i;
                    rem_d     = (req_len_i == 8'd0) ? 9'd256 : {1'b0, req_len_i};
                    hdr_idx_d = 3'd0;
                    tmo_d     = 16'd0;
                    err_d     = 1'b0;
                    state_d   = S_CS_ON;
                end
            end
            S_CS_ON: begin
                spi_we_o    = 1'b1;
                spi_addr_o  = ADDR_CTRL;
                spi_wdata_o = ctrl_word(1'b1, 1'b0);
                state_d     = S_LOAD;
            end
            S_LOAD: begin
                spi_we_o    = 1'b1;
                spi_addr_o  = ADDR_DATA;
                spi_wdata_o = {24'h0, cur_byte};
                state_d     = S_KICK;
            end
            S_KICK: begin
                spi_we_o    = 1'b1;
                spi_addr_o  = ADDR_CTRL;
                spi_wdata_o = ctrl_word(1'b1, 1'b1);
                tmo_d       = 16'd0;
                state_d     = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (spi_busy) begin
                    tmo_d   = 16'd0;
                    state_d = S_WAIT_LO;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = S_CS_OFF;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_WAIT_LO: begin
                if (!spi_busy) begin
                    state_d = S_FETCH;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = S_CS_OFF;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_FETCH: begin
                spi_addr_o = ADDR_DATA;
                if (is_hdr) begin
                    state_d = S_NEXT;
                end else begin
                    rd_data_d = spi_rdata_i[7:0];
                    state_d   = S_OUT;
                end
            end
            S_OUT: begin
                if (rd_ready_i) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                // Header slots always have payload after them (rem_q >= 1), so they loop straight back.
                if (is_hdr) begin
                    hdr_idx_d = hdr_idx_q + 3'd1;
                    state_d   = S_LOAD;
                end else if (rem_q > 9'd1) begin
                    rem_d   = rem_q - 9'd1;
                    state_d = S_LOAD;
                end else begin
                    rem_d   = 9'd0;
                    state_d = S_CS_OFF;
                end
            end
            S_CS_OFF: begin
                spi_we_o    = 1'b1;
                spi_addr_o  = ADDR_CTRL;
                spi_wdata_o = ctrl_word(1'b0, 1'b0);
                state_d     = S_DONE;
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            addr_q    <= 24'h0;
            rem_q     <= 9'd0;
            hdr_idx_q <= 3'd0;
            tmo_q     <= 16'd0;
            err_q     <= 1'b0;
            rd_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            hdr_idx_q <= hdr_idx_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign busy_o     = (state_q != S_IDLE);
    assign rd_valid_o = (state_q == S_OUT);
    assign rd_data_o  = rd_data_q;
    assign err_o      = err_q;

endmodule
